// File: rtl/x_23k640_arb_if.sv
// Bus bundle between two requesters, the round-robin arbiter and the 23K640 data engine.
// Handshake: a requester holds valid and its fields stable until the engine's accept in the same cycle.
interface x_23k640_arb_if #(
    parameter int MAX_BURST = 4
);
    localparam int CW = $clog2(MAX_BURST) + 1;

    logic        i_valid_0;
    logic        i_valid_1;
    logic        o_accept_0;
    logic        o_accept_1;
    logic        i_rd_n_wr_0;
    logic        i_rd_n_wr_1;
    logic [15:0] i_addr_0;
    logic [15:0] i_addr_1;
    logic [7:0]  i_wdata_0;
    logic [7:0]  i_wdata_1;
    logic        o_ready_0;
    logic        o_ready_1;
    logic [7:0]  o_rdata;

    logic        o_valid;
    logic        i_accept;
    logic        o_rd_n_wr;
    logic [15:0] o_addr;
    logic [7:0]  o_wdata;
    logic        i_ready;
    logic [7:0]  i_rdata;

    logic        o_err;

    // Observability of the arbiter's internal state.
    logic          dbg_owner;
    logic [CW-1:0] dbg_burst_cnt;
    logic          dbg_rd_pend;
    logic          dbg_rd_tag;

    modport slave (
        input  i_valid_0, i_valid_1, i_rd_n_wr_0, i_rd_n_wr_1,
               i_addr_0, i_addr_1, i_wdata_0, i_wdata_1,
               i_accept, i_ready, i_rdata,
        output o_accept_0, o_accept_1, o_ready_0, o_ready_1, o_rdata,
               o_valid, o_rd_n_wr, o_addr, o_wdata, o_err,
               dbg_owner, dbg_burst_cnt, dbg_rd_pend, dbg_rd_tag
    );

    modport master (
        output i_valid_0, i_valid_1, i_rd_n_wr_0, i_rd_n_wr_1,
               i_addr_0, i_addr_1, i_wdata_0, i_wdata_1,
               i_accept, i_ready, i_rdata,
        input  o_accept_0, o_accept_1, o_ready_0, o_ready_1, o_rdata,
               o_valid, o_rd_n_wr, o_addr, o_wdata, o_err,
               dbg_owner, dbg_burst_cnt, dbg_rd_pend, dbg_rd_tag
    );
endinterface

// File: rtl/x_23k640_arb.sv
// Two-requester round-robin arbiter for the 23K640 engine: burst-limited grant holding
// and read-completion steering back to the issuing requester.
module x_23k640_arb #(
    parameter int MAX_BURST = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    x_23k640_arb_if.slave   bus
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    logic          owner;
    logic [CW-1:0] burst_cnt;
    logic          rd_pend;
    logic          rd_tag;
    logic          err;

    logic valid_own;
    logic valid_oth;

    assign valid_own = owner ? bus.i_valid_1 : bus.i_valid_0;
    assign valid_oth = owner ? bus.i_valid_0 : bus.i_valid_1;

    // owner only moves on an edge where its request was accepted or is idle,
    // so the engine never sees the fields change mid-request.
    assign bus.o_valid   = valid_own;
    assign bus.o_rd_n_wr = owner ? bus.i_rd_n_wr_1 : bus.i_rd_n_wr_0;
    assign bus.o_addr    = owner ? bus.i_addr_1    : bus.i_addr_0;
    assign bus.o_wdata   = owner ? bus.i_wdata_1   : bus.i_wdata_0;

    assign bus.o_accept_0 = bus.i_accept & ~owner;
    assign bus.o_accept_1 = bus.i_accept &  owner;

    assign bus.o_ready_0 = bus.i_ready & rd_pend & ~rd_tag;
    assign bus.o_ready_1 = bus.i_ready & rd_pend &  rd_tag;
    assign bus.o_rdata   = bus.i_rdata;
    assign bus.o_err     = err;

    assign bus.dbg_owner     = owner;
    assign bus.dbg_burst_cnt = burst_cnt;
    assign bus.dbg_rd_pend   = rd_pend;
    assign bus.dbg_rd_tag    = rd_tag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner     <= 1'b0;
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_tag    <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (bus.i_accept && (burst_cnt == LAST) && valid_oth) begin
                owner     <= ~owner;
                burst_cnt <= '0;
            end else if (bus.i_accept) begin
                if (burst_cnt != LAST) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else if (!valid_own && valid_oth) begin
                owner     <= ~owner;
                burst_cnt <= '0;
            end

            // A new read accept takes precedence over a completion in the same cycle.
            if (bus.i_accept && bus.o_rd_n_wr) begin
                rd_pend <= 1'b1;
                rd_tag  <= owner;
            end else if (bus.i_ready) begin
                rd_pend <= 1'b0;
            end

            if ((bus.i_ready && !rd_pend) || (bus.i_accept && !valid_own)) begin
                err <= 1'b1;
            end
        end
    end
endmodule
